if_id_skid_reg: RTL and testbench
=================================

IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 Parameter PC_W, default 32: width of the PC field.
REQ-002 Parameter INSTR_W, default 32: width of the instruction field.
REQ-003 Parameter NOP_INSTR, default 0 at INSTR_W bits: bubble instruction emitted when empty, flushed or reset.
REQ-004 Parameter CNT_W, default 16: width of the drop counter.
REQ-005 Ports, in order; clock and reset are first:
  clk  in  1  single clock; all state updates on its rising edge.
  reset  in  1  synchronous, active-high reset.
  in_valid  in  1  upstream IF entry present.
  in_ready  out  1  stage can accept an entry this cycle.
  next_pc  in  PC_W  IF next-PC.
  instruction  in  INSTR_W  fetched instruction.
  hit  in  1  I-cache hit flag.
  flush  in  1  discard all held entries (branch/jump redirect).
  out_valid  out  1  ID-side entry present.
  out_ready  in  1  ID accepts the entry this cycle.
  next_pc_out  out  PC_W  held next-PC.
  instruction_out  out  INSTR_W  held instruction, or NOP_INSTR when out_valid=0.
  hit_out  out  1  held hit, or 0 when out_valid=0.
  drop_count  out  CNT_W  saturating count of entries discarded by flush.

Function
REQ-006 Two-entry skid buffer: MAIN drives the outputs; SKID holds the overflow entry. States are EMPTY, ONE and TWO.
REQ-007 in_ready = (state != TWO), derived from registered state only, with no combinational path from out_ready.
REQ-008 out_valid = (state != EMPTY). Outputs come from MAIN registers only, with no input-to-output combinational path.
REQ-009 Transfer in occurs when in_valid & in_ready. Transfer out occurs when out_valid & out_ready.
REQ-010 EMPTY: on in_valid, load MAIN and go to ONE; otherwise stay EMPTY.
REQ-011 ONE, both transfers: load MAIN from input, stay ONE. Zero-bubble throughput of 1 entry per cycle.
REQ-012 ONE, input transfer only: load SKID, go to TWO. MAIN holds.
REQ-013 ONE, output transfer only: go to EMPTY.
REQ-014 ONE, neither transfer: hold.
REQ-015 TWO, on out_ready: MAIN <= SKID, go to ONE. The input is not accepted in this cycle.
REQ-016 TWO, no out_ready: hold all state.
REQ-017 Entries leave in strict FIFO order; none is lost or duplicated unless flushed.
REQ-018 Latency: an entry accepted at edge N is visible at the outputs after edge N when MAIN was empty or being drained, otherwise after the edge that moves it from SKID.
REQ-019 When out_valid=0, outputs are instruction_out = NOP_INSTR and hit_out = 0, and next_pc_out holds its last value.
REQ-020 Flush, taking priority over all transfers:
  - next state is EMPTY;
  - MAIN instruction <= NOP_INSTR and hit <= 0;
  - the input in the flush cycle is dropped, even when in_ready=1;
  - no output transfer is counted.
REQ-021 drop_count increments on a flush edge by the number of valid entries held, 0, 1 or 2. It does not count the dropped input beat. It saturates at 2^CNT_W-1 and does not wrap.
REQ-022 All arithmetic is unsigned at CNT_W. Saturation is checked before the add, so that 2^CNT_W-2 plus 2 gives 2^CNT_W-1.

Reset
REQ-023 reset is synchronous and active-high, and takes priority over flush and all transfers.
REQ-024 Reset values: state EMPTY, out_valid 0, in_ready 1, next_pc_out 0, instruction_out NOP_INSTR, hit_out 0, drop_count 0.
REQ-025 Reset asserted in TWO discards both entries. drop_count is cleared, not incremented.
REQ-026 The first accepted beat after reset deassertion is the beat presented in the cycle reset is low.

Verification
REQ-027 Reset, then in_valid=1, next_pc=0x4, instruction=0x00000010, hit=1, out_ready=1 -> after 1 edge: out_valid=1, next_pc_out=0x4, instruction_out=0x00000010, hit_out=1.
REQ-028 Back-to-back test:
  - stimulus: stream PCs 0x4, 0x8, 0xC, 0x10 with out_ready held at 1;
  - required response: outputs show them on 4 consecutive cycles, and in_ready stays at 1 throughout.
REQ-029 Stall test:
  - stimulus: send 0x4 then 0x8 with out_ready=0;
  - required response: state TWO, in_ready=0, outputs hold 0x4;
  - then raise out_ready for 1 cycle -> outputs 0x8, in_ready=1.
REQ-030 Flush in TWO with in_valid=1 carrying 0xC:
  - required response: out_valid=0, instruction_out=NOP_INSTR, hit_out=0, drop_count=2;
  - 0xC never appears at the outputs.
REQ-031 Saturation test:
  - setup: CNT_W=2 with drop_count=2;
  - stimulus: flush while in TWO;
  - required response: drop_count=3, and a further flush while in ONE keeps it at 3.
REQ-032 Reset while in TWO with flush=1 -> next cycle: EMPTY, drop_count=0, next_pc_out=0.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register built as a two-entry skid buffer.
// in_ready and all outputs come from registered state only, so there is no combinational path through the stage.
module if_id_skid_reg #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    next_pc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               hit,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    next_pc_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               hit_out,
    output logic [CNT_W-1:0]   drop_count
);

    localparam logic [1:0]       EMPTY   = 2'd0;
    localparam logic [1:0]       ONE     = 2'd1;
    localparam logic [1:0]       TWO     = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]         state_q,     state_d;
    logic [PC_W-1:0]    mainPc_q,    mainPc_d;
    logic [INSTR_W-1:0] mainInstr_q, mainInstr_d;
    logic               mainHit_q,   mainHit_d;
    logic [PC_W-1:0]    skidPc_q,    skidPc_d;
    logic [INSTR_W-1:0] skidInstr_q, skidInstr_d;
    logic               skidHit_q,   skidHit_d;
    logic [CNT_W-1:0]   dropCnt_q,   dropCnt_d;

    logic               inFire;
    logic               outFire;
    logic [CNT_W:0]     heldCnt;
    logic [CNT_W:0]     dropSum;

    assign in_ready        = (state_q != TWO);
    assign out_valid       = (state_q != EMPTY);
    assign next_pc_out     = mainPc_q;
    assign instruction_out = out_valid ? mainInstr_q : NOP_INSTR;
    assign hit_out         = out_valid & mainHit_q;
    assign drop_count      = dropCnt_q;

    assign inFire  = in_valid & in_ready;
    assign outFire = out_valid & out_ready;

    // Sum is one bit wider than the counter so the saturation test sees any carry.
    always_comb begin
        heldCnt = '0;
        if (state_q == TWO) begin
            heldCnt = (CNT_W+1)'(2);
        end else if (state_q == ONE) begin
            heldCnt = (CNT_W+1)'(1);
        end
        dropSum = {1'b0, dropCnt_q} + heldCnt;
    end

    always_comb begin
        state_d     = state_q;
        mainPc_d    = mainPc_q;
        mainInstr_d = mainInstr_q;
        mainHit_d   = mainHit_q;
        skidPc_d    = skidPc_q;
        skidInstr_d = skidInstr_q;
        skidHit_d   = skidHit_q;
        dropCnt_d   = dropCnt_q;

        if (flush) begin
            state_d     = EMPTY;
            mainInstr_d = NOP_INSTR;
            mainHit_d   = 1'b0;
            dropCnt_d   = (dropSum > {1'b0, CNT_MAX}) ? CNT_MAX : dropSum[CNT_W-1:0];
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        mainPc_d    = next_pc;
                        mainInstr_d = instruction;
                        mainHit_d   = hit;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (inFire && outFire) begin
                        mainPc_d    = next_pc;
                        mainInstr_d = instruction;
                        mainHit_d   = hit;
                    end else if (inFire) begin
                        skidPc_d    = next_pc;
                        skidInstr_d = instruction;
                        skidHit_d   = hit;
                        state_d     = TWO;
                    end else if (outFire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // Input is blocked this cycle, so only the skid entry advances.
                    if (out_ready) begin
                        mainPc_d    = skidPc_q;
                        mainInstr_d = skidInstr_q;
                        mainHit_d   = skidHit_q;
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            mainPc_q    <= '0;
            mainInstr_q <= NOP_INSTR;
            mainHit_q   <= 1'b0;
            skidPc_q    <= '0;
            skidInstr_q <= NOP_INSTR;
            skidHit_q   <= 1'b0;
            dropCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mainPc_q    <= mainPc_d;
            mainInstr_q <= mainInstr_d;
            mainHit_q   <= mainHit_d;
            skidPc_q    <= skidPc_d;
            skidInstr_q <= skidInstr_d;
            skidHit_q   <= skidHit_d;
            dropCnt_q   <= dropCnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model of the stage.
module tb_if_id_skid_reg;

    localparam int          PC_W    = 32;
    localparam int          INSTR_W = 32;
    localparam int          CNT_W   = 2;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    next_pc;
    logic [INSTR_W-1:0] instruction;
    logic               hit;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    next_pc_out;
    logic [INSTR_W-1:0] instruction_out;
    logic               hit_out;
    logic [CNT_W-1:0]   drop_count;

    int checks   = 0;
    int failures = 0;
    bit chkEn    = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        hit;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mPc;
    int          mCnt;

    if_id_skid_reg #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .next_pc(next_pc), .instruction(instruction), .hit(hit),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .next_pc_out(next_pc_out), .instruction_out(instruction_out), .hit_out(hit_out),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic fl, input logic iv, input logic [31:0] pc,
                                 input logic [31:0] ins, input logic h, input logic ordy);
        reset       = rst;
        flush       = fl;
        in_valid    = iv;
        next_pc     = pc;
        instruction = ins;
        hit         = h;
        out_ready   = ordy;
        @(posedge clk);
        #2;
    endtask

    // Model: the stage is a FIFO of depth two; the head is what ID sees.
    always @(posedge clk) begin
        entry_t e;
        bit     doPop;
        bit     doPush;
        int     sum;
        if (reset) begin
            mq.delete();
            mPc  = '0;
            mCnt = 0;
        end else if (flush) begin
            sum  = mCnt + mq.size();
            mCnt = (sum > CNT_MAX) ? CNT_MAX : sum;
            mq.delete();
        end else begin
            doPop  = (mq.size() > 0) && out_ready;
            doPush = in_valid && (mq.size() < 2);
            e.pc    = next_pc;
            e.instr = instruction;
            e.hit   = hit;
            if (doPop)  void'(mq.pop_front());
            if (doPush) mq.push_back(e);
            if (mq.size() > 0) mPc = mq[0].pc;
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            bit v;
            v = (mq.size() != 0);
            checkOutput("m_in_ready",  64'(in_ready),        64'(mq.size() < 2));
            checkOutput("m_out_valid", 64'(out_valid),       64'(v));
            checkOutput("m_pc",        64'(next_pc_out),     64'(mPc));
            checkOutput("m_instr",     64'(instruction_out), v ? 64'(mq[0].instr) : 64'(NOP));
            checkOutput("m_hit",       64'(hit_out),         v ? 64'(mq[0].hit) : 64'd0);
            checkOutput("m_drop",      64'(drop_count),      64'(mCnt));
        end
    end

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        chkEn = 1'b1;
        checkOutput("rst_valid", 64'(out_valid),       64'd0);
        checkOutput("rst_ready", 64'(in_ready),        64'd1);
        checkOutput("rst_pc",    64'(next_pc_out),     64'd0);
        checkOutput("rst_instr", 64'(instruction_out), 64'(NOP));
        checkOutput("rst_drop",  64'(drop_count),      64'd0);

        applyStimulus(0, 0, 1, 32'h4, 32'h10, 1, 1);
        checkOutput("first_valid", 64'(out_valid),       64'd1);
        checkOutput("first_pc",    64'(next_pc_out),     64'h4);
        checkOutput("first_instr", 64'(instruction_out), 64'h10);
        checkOutput("first_hit",   64'(hit_out),         64'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 1, 32'(4 * i), 32'(100 + i), 1'(i), 1);
            checkOutput("b2b_pc",    64'(next_pc_out), 64'(4 * i));
            checkOutput("b2b_ready", 64'(in_ready),    64'd1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("drain_valid", 64'(out_valid), 64'd0);

        applyStimulus(0, 0, 1, 32'h4, 32'h44, 0, 0);
        applyStimulus(0, 0, 1, 32'h8, 32'h88, 1, 0);
        checkOutput("stall_ready", 64'(in_ready),    64'd0);
        checkOutput("stall_pc",    64'(next_pc_out), 64'h4);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("unstall_pc",    64'(next_pc_out), 64'h8);
        checkOutput("unstall_ready", 64'(in_ready),    64'd1);

        applyStimulus(0, 0, 1, 32'h20, 32'h200, 1, 0);
        applyStimulus(0, 1, 1, 32'hC, 32'hCC, 1, 0);
        checkOutput("flush_valid", 64'(out_valid),       64'd0);
        checkOutput("flush_instr", 64'(instruction_out), 64'(NOP));
        checkOutput("flush_hit",   64'(hit_out),         64'd0);
        checkOutput("flush_drop",  64'(drop_count),      64'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("flush_noC", 64'(out_valid), 64'd0);

        applyStimulus(0, 0, 1, 32'h30, 32'h300, 0, 0);
        applyStimulus(0, 0, 1, 32'h34, 32'h340, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("sat_drop", 64'(drop_count), 64'd3);
        applyStimulus(0, 0, 1, 32'h38, 32'h380, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("sat_hold", 64'(drop_count), 64'd3);

        applyStimulus(0, 0, 1, 32'h40, 32'h400, 1, 0);
        applyStimulus(0, 0, 1, 32'h44, 32'h440, 1, 0);
        applyStimulus(1, 1, 1, 32'h48, 32'h480, 1, 0);
        checkOutput("rstTwo_valid", 64'(out_valid),   64'd0);
        checkOutput("rstTwo_drop",  64'(drop_count),  64'd0);
        checkOutput("rstTwo_pc",    64'(next_pc_out), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 9) < 7), $urandom, $urandom, 1'($urandom),
                          ($urandom_range(0, 9) < 6));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
